ex_div_sequencer: RTL and testbench

//  Iterative radix-2 restoring divider for the execute stage's DIV/REM opcodes (4'd7/4'd8), replacing single-cycle '/' and '%'.

---
 rtl/ex_div_sequencer_pkg.sv | 20 ++
 rtl/ex_div_sequencer_if.sv | 29 ++
 rtl/ex_div_sequencer_div_step.sv | 25 ++
 rtl/ex_div_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ex_div_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ex_div_sequencer_pkg.sv
// Shared opcode constants and divider FSM state type for the execute-stage divide sequencer.
package ex_div_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SL  = 4'd5;
    localparam logic [3:0] OP_SR  = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;
    localparam logic [3:0] OP_REM = 4'd8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_sequencer_if.sv
// Request/response handshake between the execute stage (master) and the divide sequencer (slave).
interface ex_div_sequencer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_rem;
    logic                  req_signed;
    logic                  req_word;
    logic [DATA_WIDTH-1:0] req_dividend;
    logic [DATA_WIDTH-1:0] req_divisor;
    logic [4:0]            req_dst_reg;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic [4:0]            resp_dst_reg;

    modport master (
        output req_valid, req_is_rem, req_signed, req_word, req_dividend, req_divisor,
               req_dst_reg, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_dst_reg
    );

    modport slave (
        input  req_valid, req_is_rem, req_signed, req_word, req_dividend, req_divisor,
               req_dst_reg, resp_ready,
        output req_ready, resp_valid, resp_result, resp_dst_reg
    );
endinterface

// File: rtl/ex_div_sequencer_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and shift the quotient bit in.
module ex_div_sequencer_div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);
    // One extra bit: the shifted remainder can exceed W bits before the subtract.
    logic [W:0] trial;

    always_comb begin
        trial = {rem_in, quo_in[W-1]};
        if (trial >= {1'b0, divisor}) begin
            rem_out = trial[W-1:0] - divisor;
            quo_out = {quo_in[W-2:0], 1'b1};
        end else begin
            rem_out = trial[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_div_sequencer.sv
// Iterative radix-2 restoring divider for DIV/REM: one op in flight, IDLE->RUN->DONE handshake,
// with divide-by-zero and signed overflow resolved at accept time.
module ex_div_sequencer
    import ex_div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    ex_div_sequencer_if.slave    div,
    output logic                 busy
);
    localparam int W  = DATA_WIDTH;
    localparam int H  = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    div_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvsr_q, dvsr_d;
    logic [W-1:0]   res_q, res_d;
    logic [4:0]     dst_q, dst_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           is_rem_q, is_rem_d;
    logic           word_q, word_d;

    // Accept-side operand conditioning
    logic [W-1:0]   a_ext, b_ext, a_adj, a_mag, b_mag, min_val;
    logic           a_neg, b_neg, div_zero, ovf;

    always_comb begin
        if (div.req_word) begin
            a_ext = div.req_signed ? {{H{div.req_dividend[H-1]}}, div.req_dividend[H-1:0]}
                                   : {{H{1'b0}}, div.req_dividend[H-1:0]};
            b_ext = div.req_signed ? {{H{div.req_divisor[H-1]}}, div.req_divisor[H-1:0]}
                                   : {{H{1'b0}}, div.req_divisor[H-1:0]};
            a_adj   = {{H{div.req_dividend[H-1]}}, div.req_dividend[H-1:0]};
            min_val = {{(H+1){1'b1}}, {(H-1){1'b0}}};
        end else begin
            a_ext   = div.req_dividend;
            b_ext   = div.req_divisor;
            a_adj   = div.req_dividend;
            min_val = {1'b1, {(W-1){1'b0}}};
        end
        a_neg    = div.req_signed & a_ext[W-1];
        b_neg    = div.req_signed & b_ext[W-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = div.req_signed && (a_ext == min_val) && (b_ext == '1);
    end

    logic [W-1:0] step_rem, step_quo;

    ex_div_sequencer_div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Sign fix-up of the final iteration's output, then word sign-extension.
    logic [W-1:0] q_fix, r_fix, sel, fin;

    always_comb begin
        q_fix = q_neg_q ? -step_quo : step_quo;
        r_fix = r_neg_q ? -step_rem : step_rem;
        sel   = is_rem_q ? r_fix : q_fix;
        fin   = word_q ? {{H{sel[H-1]}}, sel[H-1:0]} : sel;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        res_d    = res_q;
        dst_d    = dst_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        word_d   = word_q;

        case (state_q)
            DIV_IDLE: begin
                if (div.req_valid) begin
                    is_rem_d = div.req_is_rem;
                    word_d   = div.req_word;
                    dst_d    = div.req_dst_reg;
                    if (div_zero) begin
                        res_d   = div.req_is_rem ? a_adj : '1;
                        state_d = DIV_DONE;
                    end else if (ovf) begin
                        // MIN / -1: the quotient is the dividend itself
                        res_d   = div.req_is_rem ? '0 : a_adj;
                        state_d = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = div.req_word ? (a_mag << H) : a_mag;
                        dvsr_d  = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = div.req_word ? CW'(H) : CW'(W);
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = fin;
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (div.resp_ready) begin
                    res_d   = '0;
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            res_q    <= '0;
            dst_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            res_q    <= res_d;
            dst_q    <= dst_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            word_q   <= word_d;
        end
    end

    assign div.req_ready    = (state_q == DIV_IDLE);
    assign div.resp_valid   = (state_q == DIV_DONE);
    assign div.resp_result  = res_q;
    assign div.resp_dst_reg = dst_q;
    assign busy             = (state_q != DIV_IDLE);
endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed bench for ex_div_sequencer: hand-computed quotients/remainders, latencies and handshake corners.
module tb_ex_div_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    ex_div_sequencer_if #(.DATA_WIDTH(64)) dif ();

    ex_div_sequencer #(.DATA_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .div   (dif),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit rem, input bit sgn, input bit wrd,
                             input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst);
        dif.req_valid    = 1'b1;
        dif.req_is_rem   = rem;
        dif.req_signed   = sgn;
        dif.req_word     = wrd;
        dif.req_dividend = a;
        dif.req_divisor  = b;
        dif.req_dst_reg  = dst;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!dif.resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input bit rem, input bit sgn, input bit wrd,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        drive_req(rem, sgn, wrd, a, b, dst);
        dif.resp_ready = 1'b0;
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        wait_resp(lat);
        chk({tag, "_res"}, dif.resp_result, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_dst"}, 64'(dif.resp_dst_reg), 64'(dst));
        dif.resp_ready = 1'b1;
        @(posedge clk); #1;
        dif.resp_ready = 1'b0;
        chk({tag, "_idle"}, {62'd0, dif.resp_valid, dif.req_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int cyc;
        int acc0;
        int acc1;
        reset = 1'b1;
        flush = 1'b0;
        dif.req_valid = 1'b0;
        dif.req_is_rem = 1'b0;
        dif.req_signed = 1'b0;
        dif.req_word = 1'b0;
        dif.req_dividend = '0;
        dif.req_divisor = '0;
        dif.req_dst_reg = '0;
        dif.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {59'd0, dif.req_ready, dif.resp_valid, busy, 2'b00}, 64'b10000);
        chk("rst_res", dif.resp_result, 64'd0);
        chk("rst_dst", 64'(dif.resp_dst_reg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("u100d7",  0, 0, 0, 64'd100, 64'd7, 5'd1, 64'd14, 65);
        run_op("u100r7",  1, 0, 0, 64'd100, 64'd7, 5'd2, 64'd2, 65);
        run_op("sm7d2",   0, 1, 0, -64'sd7, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("sm7r2",   1, 1, 0, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("s7rm2",   1, 1, 0, 64'd7, -64'sd2, 5'd5, 64'd1, 65);
        run_op("wovf",    0, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("d0quo",   0, 0, 0, 64'd42, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("d0rem",   1, 0, 0, 64'd42, 64'd0, 5'd8, 64'd42, 1);
        run_op("s64ovf",  0, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
               64'h8000_0000_0000_0000, 1);
        run_op("s64ovfr", 1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
               64'd0, 1);
        run_op("uwdiv",   0, 0, 1, 64'h1234_5678_FFFF_FFF0, 64'h0000_0000_0000_0010, 5'd11,
               64'h0000_0000_0FFF_FFFF, 33);
        run_op("uwsext",  0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12,
               64'hFFFF_FFFF_FFFF_FFFF, 33);

        // Hold in DONE with resp_ready low while a new request is offered
        @(negedge clk);
        drive_req(0, 0, 0, 64'd9, 64'd3, 5'd13);
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        wait_resp(lat);
        chk("hold_lat", 64'(lat), 64'd65);
        @(negedge clk);
        drive_req(0, 0, 0, 64'd50, 64'd5, 5'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_vld_rdy", {62'd0, dif.resp_valid, dif.req_ready}, 64'b10);
            chk("hold_res", dif.resp_result, 64'd3);
        end
        chk("hold_dst", 64'(dif.resp_dst_reg), 64'd13);
        @(negedge clk);
        dif.req_valid = 1'b0;
        dif.resp_ready = 1'b1;
        @(posedge clk); #1;
        dif.resp_ready = 1'b0;
        chk("hold_rel", {62'd0, dif.resp_valid, busy}, 64'd0);

        // Flush 20 cycles into RUN
        @(negedge clk);
        drive_req(0, 0, 0, 64'd100, 64'd7, 5'd15);
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("pre_flush_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_outs", {61'd0, dif.req_ready, dif.resp_valid, busy}, 64'b100);
        chk("flush_res", dif.resp_result, 64'd0);
        cyc = 0;
        while (cyc < 80) begin
            @(posedge clk); #1;
            if (dif.resp_valid) break;
            cyc++;
        end
        chk("flush_no_resp", 64'(cyc), 64'd80);
        run_op("post_flush", 0, 0, 0, 64'd9, 64'd3, 5'd16, 64'd3, 65);

        // flush together with req_valid in IDLE: request dropped
        @(negedge clk);
        drive_req(0, 0, 0, 64'd9, 64'd3, 5'd17);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        dif.req_valid = 1'b0;
        chk("flush_idle_drop", {62'd0, busy, dif.req_ready}, 64'b01);

        // Reset mid-RUN
        @(negedge clk);
        drive_req(0, 0, 0, 64'd1000, 64'd3, 5'd18);
        @(posedge clk); #1;
        dif.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstrun_outs", {61'd0, dif.req_ready, dif.resp_valid, busy}, 64'b100);
        chk("rstrun_res", dif.resp_result, 64'd0);
        chk("rstrun_dst", 64'(dif.resp_dst_reg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back with req_valid and resp_ready held high
        @(negedge clk);
        drive_req(0, 0, 0, 64'd77, 64'd7, 5'd19);
        dif.resp_ready = 1'b1;
        acc0 = -1;
        acc1 = -1;
        for (int c = 0; c < 200 && acc1 < 0; c++) begin
            if (dif.req_ready && dif.req_valid) begin
                if (acc0 < 0) acc0 = c;
                else acc1 = c;
            end
            @(negedge clk);
        end
        dif.req_valid = 1'b0;
        dif.resp_ready = 1'b0;
        chk("b2b_spacing", 64'(acc1 - acc0), 64'd66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
